// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants, output bundle and axis helpers,
// used by the timing generator, the output stage and the pixel source.
package vga_timing_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef struct packed {
        logic           sync_color;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           hs;
        logic           vs;
        logic           line_start;
        logic           frame_start;
    } vga_out_t;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Raster timing bundle between the sync generator and its consumers
// (colour gating stage, connector pins, pixel source strobes).
interface vga_sync_if;
    import vga_timing_pkg::*;

    logic           SYNC_COLOR;
    logic [X_W-1:0] Current_X;
    logic [Y_W-1:0] Current_Y;
    logic           oVGA_HS;
    logic           oVGA_VS;
    logic           oLINE_START;
    logic           oFRAME_START;

    modport master (
        output SYNC_COLOR, Current_X, Current_Y,
        output oVGA_HS, oVGA_VS, oLINE_START, oFRAME_START
    );

    modport slave (
        input SYNC_COLOR, Current_X, Current_Y,
        input oVGA_HS, oVGA_VS, oLINE_START, oFRAME_START
    );
endinterface

// File: rtl/vga_axis_counter.sv
// Single-axis raster counter: wraps at the axis total and decodes
// the visible window and sync window of the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             active_o,
    output logic             sync_o
);
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO  = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI  = CNT_W'(ACTIVE + FP + SYNC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // inclusive upper bound keeps the compare inside CNT_W when TOTAL hits 1024
    assign cnt_o    = cnt_q;
    assign active_o = (cnt_q < ACT_END);
    assign sync_o   = (cnt_q >= SYNC_LO) && (cnt_q <= SYNC_HI);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: free-running h/v counters with a
// registered decode stage, so every output lags the counters by one clock.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SYNC_POL = 0
) (
    input  logic              VGA_CLK,
    input  logic              RESET,
    vga_sync_if.master        vga
);
    localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic             POL    = (SYNC_POL != 0);

    localparam vga_out_t OUT_RST = '{
        sync_color:  1'b0,
        x:           '0,
        y:           '0,
        hs:          ~POL,
        vs:          ~POL,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    if (H_ACTIVE > 1023 || V_ACTIVE > 511 ||
        H_TOT > 1024 || V_TOT > 1024) begin : g_width_check
        $error("vga_sync_gen: timing does not fit counter/coordinate widths");
    end

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_act, v_act, h_sync, v_sync;
    logic             h_last, active;
    vga_out_t         out_q, out_d;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk_i    (VGA_CLK),
        .rst_i    (RESET),
        .adv_i    (1'b1),
        .cnt_o    (h_cnt),
        .active_o (h_act),
        .sync_o   (h_sync)
    );

    // vertical axis steps once per line, on the horizontal wrap
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk_i    (VGA_CLK),
        .rst_i    (RESET),
        .adv_i    (h_last),
        .cnt_o    (v_cnt),
        .active_o (v_act),
        .sync_o   (v_sync)
    );

    assign h_last = (h_cnt == H_LAST);
    assign active = h_act && v_act;

    always_comb begin
        out_d             = OUT_RST;
        out_d.sync_color  = active;
        out_d.x           = active ? X_W'(h_cnt + 1'b1) : '0;
        out_d.y           = active ? Y_W'(v_cnt + 1'b1) : '0;
        out_d.hs          = h_sync ? POL : ~POL;
        out_d.vs          = v_sync ? POL : ~POL;
        out_d.line_start  = (h_cnt == '0);
        out_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            out_q <= OUT_RST;
        end else begin
            out_q <= out_d;
        end
    end

    assign vga.SYNC_COLOR   = out_q.sync_color;
    assign vga.Current_X    = out_q.x;
    assign vga.Current_Y    = out_q.y;
    assign vga.oVGA_HS      = out_q.hs;
    assign vga.oVGA_VS      = out_q.vs;
    assign vga.oLINE_START  = out_q.line_start;
    assign vga.oFRAME_START = out_q.frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance and a tiny raster
// instance, both checked against a position-based reference model.
module tb_vga_sync_gen;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    int vectors = 0;
    int errors  = 0;
    int ka      = 0;

    vga_sync_if vif_a ();
    vga_sync_if vif_b ();

    vga_sync_gen dut_a (
        .VGA_CLK (clk),
        .RESET   (rst_a),
        .vga     (vif_a)
    );

    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1)
    ) dut_b (
        .VGA_CLK (clk),
        .RESET   (rst_b),
        .vga     (vif_b)
    );

    always #5 clk = ~clk;

    // {color, x[10], y[9], hs, vs, line_start, frame_start}
    wire [23:0] out_a = {vif_a.SYNC_COLOR, vif_a.Current_X, vif_a.Current_Y,
                         vif_a.oVGA_HS, vif_a.oVGA_VS,
                         vif_a.oLINE_START, vif_a.oFRAME_START};
    wire [23:0] out_b = {vif_b.SYNC_COLOR, vif_b.Current_X, vif_b.Current_Y,
                         vif_b.oVGA_HS, vif_b.oVGA_VS,
                         vif_b.oLINE_START, vif_b.oFRAME_START};

    localparam logic [23:0] RST_A = 24'h00000C;
    localparam logic [23:0] RST_B = 24'h000000;

    function automatic logic [23:0] ref_out(
        input int h, input int v,
        input int ha, input int hfp, input int hsw,
        input int va, input int vfp, input int vsw, input bit pol);
        bit act, hs_on, vs_on;
        act   = (h < ha) && (v < va);
        hs_on = (h >= ha + hfp) && (h < ha + hfp + hsw);
        vs_on = (v >= va + vfp) && (v < va + vfp + vsw);
        return {act,
                act ? 10'(h + 1) : 10'd0,
                act ? 9'(v + 1) : 9'd0,
                hs_on ? pol : ~pol,
                vs_on ? pol : ~pol,
                h == 0,
                (h == 0) && (v == 0)};
    endfunction

    // k-th output sample after reset release shows raster position k
    function automatic logic [23:0] exp_a(input int k);
        return ref_out(k % 800, (k / 800) % 525, 640, 16, 96, 480, 10, 2, 1'b0);
    endfunction

    function automatic logic [23:0] exp_b(input int k);
        return ref_out(k % 16, (k / 16) % 7, 8, 2, 3, 4, 1, 1, 1'b1);
    endfunction

    task automatic test_reset();
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (out_a !== RST_A) begin
                errors++;
                $display("FAIL reset_a got %h want %h", out_a, RST_A);
            end
            vectors++;
            if (out_b !== RST_B) begin
                errors++;
                $display("FAIL reset_b got %h want %h", out_b, RST_B);
            end
        end
    endtask

    task automatic test_first_lines();
        int hs_low = 0;
        int hs_st0 = -1;
        int hs_st1 = -1;
        int ls0 = -1;
        int ls1 = -1;
        logic prev_hs = 1'b1;
        logic [23:0] e;
        rst_a = 1'b0;
        for (int k = 0; k < 1700; k++) begin
            @(negedge clk);
            e = exp_a(k);
            vectors++;
            if (out_a !== e) begin
                errors++;
                $display("FAIL line_trace k=%0d got %h want %h", k, out_a, e);
            end
            if (k < 800 && out_a[3] == 1'b0) hs_low++;
            if (prev_hs && !out_a[3]) begin
                if (hs_st0 < 0) hs_st0 = k;
                else if (hs_st1 < 0) hs_st1 = k;
            end
            prev_hs = out_a[3];
            if (out_a[1]) begin
                if (ls0 < 0) ls0 = k;
                else if (ls1 < 0) ls1 = k;
            end
        end
        ka = 1700;
        vectors++;
        if (hs_low !== 96) begin
            errors++;
            $display("FAIL hs_width got %0d want 96", hs_low);
        end
        vectors++;
        if (hs_st0 !== 656) begin
            errors++;
            $display("FAIL hs_start got %0d want 656", hs_st0);
        end
        vectors++;
        if (hs_st1 - hs_st0 !== 800) begin
            errors++;
            $display("FAIL hs_period got %0d want 800", hs_st1 - hs_st0);
        end
        vectors++;
        if (ls0 !== 0 || ls1 - ls0 !== 800) begin
            errors++;
            $display("FAIL line_period first=%0d period=%0d want 0/800",
                     ls0, ls1 - ls0);
        end
    endtask

    task automatic test_async_reset_a();
        int target;
        logic [23:0] e;
        target = 1600 + 300 + int'($urandom_range(0, 99));
        while (ka <= target) begin
            @(negedge clk);
            e = exp_a(ka);
            vectors++;
            if (out_a !== e) begin
                errors++;
                $display("FAIL pre_reset k=%0d got %h want %h", ka, out_a, e);
            end
            ka++;
        end
        @(posedge clk);
        #($urandom_range(1, 3));
        rst_a = 1'b1;
        #1;
        vectors++;
        if (out_a !== RST_A) begin
            errors++;
            $display("FAIL async_clear_a got %h want %h", out_a, RST_A);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (out_a !== RST_A) begin
            errors++;
            $display("FAIL reset_hold_a got %h want %h", out_a, RST_A);
        end
        rst_a = 1'b0;
        for (int k = 0; k < 900; k++) begin
            @(negedge clk);
            e = exp_a(k);
            vectors++;
            if (out_a !== e) begin
                errors++;
                $display("FAIL restart_a k=%0d got %h want %h", k, out_a, e);
            end
            if (k == 0) begin
                vectors++;
                if (out_a[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_restart got %b want 1", out_a[0]);
                end
            end
        end
    endtask

    task automatic test_small_frames();
        int vs_cnt = 0;
        int vs_st = -1;
        int hs_st = -1;
        int fs0 = -1;
        int fs1 = -1;
        int fs2 = -1;
        logic [23:0] e;
        rst_b = 1'b0;
        for (int k = 0; k < 336; k++) begin
            @(negedge clk);
            e = exp_b(k);
            vectors++;
            if (out_b !== e) begin
                errors++;
                $display("FAIL small_trace k=%0d got %h want %h", k, out_b, e);
            end
            if (k < 112 && out_b[2]) begin
                vs_cnt++;
                if (vs_st < 0) vs_st = k;
            end
            if (out_b[3] && hs_st < 0) hs_st = k;
            if (out_b[0]) begin
                if (fs0 < 0) fs0 = k;
                else if (fs1 < 0) fs1 = k;
                else if (fs2 < 0) fs2 = k;
            end
        end
        vectors++;
        if (vs_cnt !== 16 || vs_st !== 80) begin
            errors++;
            $display("FAIL small_vs width=%0d start=%0d want 16/80", vs_cnt, vs_st);
        end
        vectors++;
        if (hs_st !== 10) begin
            errors++;
            $display("FAIL small_hs_start got %0d want 10", hs_st);
        end
        vectors++;
        if (fs0 !== 0 || fs1 !== 112 || fs2 !== 224) begin
            errors++;
            $display("FAIL small_frame_period got %0d/%0d/%0d want 0/112/224",
                     fs0, fs1, fs2);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [23:0] e;
        for (int it = 0; it < 6; it++) begin
            @(posedge clk);
            #($urandom_range(1, 3));
            rst_b = 1'b1;
            #1;
            vectors++;
            if (out_b !== RST_B) begin
                errors++;
                $display("FAIL async_clear_b it=%0d got %h want %h", it, out_b, RST_B);
            end
            @(negedge clk);
            rst_b = 1'b0;
            n = int'($urandom_range(1, 150));
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                e = exp_b(k);
                vectors++;
                if (out_b !== e) begin
                    errors++;
                    $display("FAIL b2b it=%0d k=%0d got %h want %h", it, k, out_b, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_lines();
        test_async_reset_a();
        test_small_frames();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
